// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: turns byte or aligned word requests into single-byte
// accesses on the data memory byte port and returns a one-cycle response.
module load_store_unit (
  input  logic               clk,
  input  logic               reset_n,   // active-high asynchronous reset
  load_store_unit_if.slave   bus,
  output logic [11:0]        mem_address,
  output logic [1:0]         mem_write_enable,
  output logic [1:0]         mem_read_enable,
  output logic [7:0]         mem_write_data,
  input  logic [7:0]         mem_read_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RTAIL, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  k;
  logic [11:0] base;
  logic [31:0] wdata;
  logic [31:0] asm_data;
  logic        op_write;
  logic        op_size;
  logic        op_signed;
  logic        op_err;
  logic [1:0]  last_k;
  logic        misaligned;

  // Index of the final byte: 0 for byte operations, 3 for word operations.
  assign last_k     = op_size ? 2'd3 : 2'd0;
  assign misaligned = bus.req_size && (bus.req_addr[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus state-decoded handshake, response and enables.
  always_comb begin
    state_next       = state;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_err     = 1'b0;
    bus.resp_rdata   = 32'h0000_0000;
    mem_write_enable = 2'b00;
    mem_read_enable  = 2'b00;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (misaligned) begin
            state_next = RESP;
          end else if (bus.req_write) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        mem_write_enable = 2'b01;
        if (k == last_k) begin
          state_next = RESP;
        end else begin
          state_next = WRITE;
        end
      end
      READ: begin
        mem_read_enable = 2'b01;
        if (k == last_k) begin
          state_next = RTAIL;
        end else begin
          state_next = READ;
        end
      end
      RTAIL: begin
        state_next = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = op_err;
        if (!op_err && !op_write) begin
          if (op_size) begin
            bus.resp_rdata = asm_data;
          end else begin
            bus.resp_rdata = {{24{asm_data[7] & op_signed}}, asm_data[7:0]};
          end
        end else begin
          bus.resp_rdata = 32'h0000_0000;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, byte counter, registered memory address/data and read assembly.
  // The address/data registers are loaded at accept so the first access is
  // already on the port in the cycle after accept, with no req->mem comb path.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      k              <= 2'd0;
      base           <= 12'h000;
      wdata          <= 32'h0000_0000;
      asm_data       <= 32'h0000_0000;
      op_write       <= 1'b0;
      op_size        <= 1'b0;
      op_signed      <= 1'b0;
      op_err         <= 1'b0;
      mem_address    <= 12'h000;
      mem_write_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            k         <= 2'd0;
            base      <= bus.req_addr;
            wdata     <= bus.req_wdata;
            op_write  <= bus.req_write;
            op_size   <= bus.req_size;
            op_signed <= bus.req_signed;
            op_err    <= misaligned;
            if (!misaligned) begin
              mem_address <= bus.req_addr;
              if (bus.req_write) begin
                mem_write_data <= bus.req_wdata[7:0];
              end
            end
          end
        end
        WRITE: begin
          if (k != last_k) begin
            k              <= k + 2'd1;
            mem_address    <= base + {10'd0, k} + 12'd1;
            mem_write_data <= wdata[{k + 2'd1, 3'b000} +: 8];
          end
        end
        READ: begin
          // Memory read data lags the address by one cycle.
          if (k != 2'd0) begin
            asm_data[{k - 2'd1, 3'b000} +: 8] <= mem_read_data;
          end
          if (k != last_k) begin
            k           <= k + 2'd1;
            mem_address <= base + {10'd0, k} + 12'd1;
          end
        end
        RTAIL: begin
          asm_data[{last_k, 3'b000} +: 8] <= mem_read_data;
        end
        default: begin
          k <= k;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic [11:0] mem_address;
  logic [1:0]  mem_write_enable;
  logic [1:0]  mem_read_enable;
  logic [7:0]  mem_write_data;
  logic [7:0]  mem_read_data;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  logic [7:0] mem [4096];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with registered read, one cycle latency.
  always @(posedge clk) begin
    if (mem_read_enable == 2'b01) mem_read_data <= mem[mem_address];
    if (mem_write_enable == 2'b01) mem[mem_address] <= mem_write_data;
  end

  int errors = 0;
  int checks = 0;

  // Access log for the most recent request.
  int          n_wr, n_rd, n_bad;
  logic [11:0] wr_addr [8];
  logic [7:0]  wr_data [8];
  int          wr_cyc  [8];
  logic [11:0] rd_addr [8];
  int          rd_cyc  [8];
  int          lat;
  logic [31:0] rdata;
  logic        rerr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, log memory activity per cycle and capture the response.
  task automatic run_req(input logic wr, input logic sz, input logic sg,
                         input logic [11:0] addr, input logic [31:0] wd);
    n_wr = 0; n_rd = 0; n_bad = 0; lat = 0; rdata = 32'h0; rerr = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    check("ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (mem_write_enable == 2'b01 && n_wr < 8) begin
        wr_addr[n_wr] = mem_address; wr_data[n_wr] = mem_write_data; wr_cyc[n_wr] = cyc; n_wr++;
      end
      if (mem_read_enable == 2'b01 && n_rd < 8) begin
        rd_addr[n_rd] = mem_address; rd_cyc[n_rd] = cyc; n_rd++;
      end
      if (mem_write_enable > 2'b01 || mem_read_enable > 2'b01) n_bad++;
      if (bus.resp_valid) begin
        lat = cyc; rdata = bus.resp_rdata; rerr = bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    check("enable_encoding", n_bad, 32'd0);
    // Step into the cycle after RESP so the unit is idle again.
    @(posedge clk); #1;
    check("resp_single_pulse", {31'd0, bus.resp_valid}, 32'd0);
  endtask

  logic [7:0] exp_b [4];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = 12'h000; bus.req_wdata = 32'h0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp",     {31'd0, bus.resp_valid}, 32'd0);
    check("rst_err",      {31'd0, bus.resp_err}, 32'd0);
    check("rst_rdata",    bus.resp_rdata, 32'h0);
    check("rst_addr",     {20'd0, mem_address}, 32'h0);
    check("rst_we",       {30'd0, mem_write_enable}, 32'd0);
    check("rst_re",       {30'd0, mem_read_enable}, 32'd0);
    check("rst_wdata",    {24'd0, mem_write_data}, 32'd0);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;

    // Byte store 0x010 <- AA
    run_req(1'b1, 1'b0, 1'b0, 12'h010, 32'h0000_00AA);
    check("bst_lat", lat, 32'd2);
    check("bst_nwr", n_wr, 32'd1);
    check("bst_addr", {20'd0, wr_addr[0]}, 32'h010);
    check("bst_data", {24'd0, wr_data[0]}, 32'hAA);
    check("bst_cyc", wr_cyc[0], 32'd1);
    check("bst_rdata", rdata, 32'h0);

    // Byte load signed / unsigned
    run_req(1'b0, 1'b0, 1'b1, 12'h010, 32'h0);
    check("bld_s_lat", lat, 32'd3);
    check("bld_s_rdata", rdata, 32'hFFFF_FFAA);
    check("bld_s_nrd", n_rd, 32'd1);
    check("bld_s_rdcyc", rd_cyc[0], 32'd1);
    run_req(1'b0, 1'b0, 1'b0, 12'h010, 32'h0);
    check("bld_u_rdata", rdata, 32'h0000_00AA);

    // Word store 0x020 <- 11223344
    run_req(1'b1, 1'b1, 1'b0, 12'h020, 32'h1122_3344);
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    check("wst_lat", lat, 32'd5);
    check("wst_nwr", n_wr, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("wst_addr", {20'd0, wr_addr[i]}, 32'h020 + i);
      check("wst_data", {24'd0, wr_data[i]}, {24'd0, exp_b[i]});
      check("wst_cyc", wr_cyc[i], i + 1);
    end

    // Word load 0x020
    run_req(1'b0, 1'b1, 1'b0, 12'h020, 32'h0);
    check("wld_lat", lat, 32'd6);
    check("wld_rdata", rdata, 32'h1122_3344);
    check("wld_err", {31'd0, rerr}, 32'd0);
    check("wld_nrd", n_rd, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("wld_addr", {20'd0, rd_addr[i]}, 32'h020 + i);
      check("wld_cyc", rd_cyc[i], i + 1);
    end

    // Signed byte load of a positive byte (0x44) stays positive
    run_req(1'b0, 1'b0, 1'b1, 12'h020, 32'h0);
    check("bld_pos_rdata", rdata, 32'h0000_0044);

    // Misaligned word load
    run_req(1'b0, 1'b1, 1'b0, 12'h021, 32'h0);
    check("mis_lat", lat, 32'd1);
    check("mis_err", {31'd0, rerr}, 32'd1);
    check("mis_rdata", rdata, 32'h0);
    check("mis_access", n_wr + n_rd, 32'd0);

    // Top of memory word store and reload
    run_req(1'b1, 1'b1, 1'b0, 12'hFFC, 32'hDEAD_BEEF);
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    check("top_nwr", n_wr, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("top_addr", {20'd0, wr_addr[i]}, 32'hFFC + i);
      check("top_data", {24'd0, wr_data[i]}, {24'd0, exp_b[i]});
    end
    check("top_nowrap", {24'd0, mem[0]}, 32'h0);
    run_req(1'b0, 1'b1, 1'b0, 12'hFFC, 32'h0);
    check("top_load", rdata, 32'hDEAD_BEEF);

    // Reset during cycle 2 of a word store to 0x040
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 1'b1;
    bus.req_signed = 1'b0; bus.req_addr = 12'h040; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rms_c1_we", {30'd0, mem_write_enable}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("rms_we_drop", {30'd0, mem_write_enable}, 32'd0);
    check("rms_addr_rst", {20'd0, mem_address}, 32'h0);
    check("rms_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk); reset_n = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (bus.resp_valid) seen++;
      end
      check("rms_no_resp", seen, 32'd0);
    end
    check("rms_ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("rms_b0_kept", {24'd0, mem[12'h040]}, 32'h0D);
    check("rms_b1_unwritten", {24'd0, mem[12'h041]}, 32'h0);

    // Backpressure: second request held during a word load
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 1'b1;
    bus.req_signed = 1'b0; bus.req_addr = 12'h020; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_size = 1'b0; bus.req_addr = 12'h010;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      check("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
      check("bp_resp_valid", {31'd0, bus.resp_valid}, {31'd0, cyc == 6});
      if (cyc == 6) check("bp_first_rdata", bus.resp_rdata, 32'h1122_3344);
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check("bp_ready_after", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp_second_busy", {31'd0, bus.req_ready}, 32'd0);
    check("bp_second_addr", {20'd0, mem_address}, 32'h010);
    begin
      int c;
      c = 0;
      for (int i = 1; i <= 10; i++) begin
        if (bus.resp_valid) begin
          c = i;
          check("bp_second_rdata", bus.resp_rdata, 32'h0000_00AA);
          break;
        end
        @(posedge clk); #1;
      end
      check("bp_second_lat", c, 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
